// File: rtl/bnn_xnor_acc.sv
// bnn_xnor_acc: pipelined XNOR-popcount neuron accumulator.
// A vector of 1..MAXBEAT beats (WL bits each) is masked, XNOR-matched,
// popcounted and accumulated; the last beat yields a unipolar popcount or
// a bipolar dot product plus a thresholded sign bit.
module bnn_xnor_acc #(
    parameter int unsigned WL      = 112,
    parameter int unsigned MAXBEAT = 4,
    parameter int unsigned PW      = $clog2(WL + 1),
    parameter int unsigned ACCW    = $clog2(WL * MAXBEAT + 1) + 1
) (
    input  logic            iCLK,
    input  logic            iRSTn,
    input  logic            iEN,
    input  logic            iVALID,
    input  logic            iLAST,
    input  logic            iMODE,
    input  logic [WL-1:0]   idata,
    input  logic [WL-1:0]   iweight,
    input  logic [WL-1:0]   imask,
    input  logic [ACCW-1:0] ithresh,
    output logic            oVALID,
    output logic [ACCW-1:0] osum,
    output logic            obit,
    output logic            oOVF
);

    localparam int unsigned NP  = 1 << $clog2(WL);
    localparam int unsigned BCW = $clog2(MAXBEAT + 2);

    // Balanced adder tree: leaves padded to a power of two, pairs summed in place.
    function automatic logic [PW-1:0] popcnt(input logic [WL-1:0] v);
        logic [PW-1:0] t [NP];
        for (int unsigned i = 0; i < NP; i++) begin
            t[i] = '0;
            if (i < WL) t[i] = PW'(v[i]);
        end
        for (int unsigned w = NP / 2; w > 0; w = w / 2) begin
            for (int unsigned i = 0; i < w; i++) begin
                t[i] = t[2*i] + t[2*i+1];
            end
        end
        return t[0];
    endfunction

    // Stage 1 registers
    logic            s1_valid_q, s1_valid_d;
    logic            s1_last_q,  s1_last_d;
    logic            s1_mode_q,  s1_mode_d;
    logic [WL-1:0]   s1_x_q,     s1_x_d;
    logic [WL-1:0]   s1_mask_q,  s1_mask_d;
    // Stage 2 registers
    logic            s2_valid_q, s2_valid_d;
    logic            s2_last_q,  s2_last_d;
    logic            s2_mode_q,  s2_mode_d;
    logic [PW-1:0]   s2_pop_q,   s2_pop_d;
    logic [PW-1:0]   s2_cnt_q,   s2_cnt_d;
    // Stage 3 accumulator state
    logic            s3_res_q,   s3_res_d;
    logic            s3_mode_q,  s3_mode_d;
    logic            first_q,    first_d;
    logic [ACCW-1:0] acc_pop_q,  acc_pop_d;
    logic [ACCW-1:0] acc_n_q,    acc_n_d;
    logic [BCW-1:0]  beat_cnt_q, beat_cnt_d;
    logic            ovf_q,      ovf_d;
    // Output registers
    logic            ovalid_q,   ovalid_d;
    logic [ACCW-1:0] osum_q,     osum_d;
    logic            obit_q,     obit_d;
    logic            oovf_q,     oovf_d;

    // Stage 1/2 datapath: XNOR-mask capture, then popcounts of match and mask
    always_comb begin
        s1_valid_d = iVALID;
        s1_last_d  = iLAST;
        s1_mode_d  = iMODE;
        s1_x_d     = ~(idata ^ iweight) & imask;
        s1_mask_d  = imask;
        s2_valid_d = s1_valid_q;
        s2_last_d  = s1_last_q;
        s2_mode_d  = s1_mode_q;
        s2_pop_d   = popcnt(s1_x_q);
        s2_cnt_d   = popcnt(s1_mask_q);
    end

    // Stage 3: accumulate across beats; first flag restarts sums, counter and ovf
    always_comb begin
        s3_res_d   = s2_valid_q & s2_last_q;
        s3_mode_d  = s3_mode_q;
        first_d    = first_q;
        acc_pop_d  = acc_pop_q;
        acc_n_d    = acc_n_q;
        beat_cnt_d = beat_cnt_q;
        ovf_d      = ovf_q;
        if (s2_valid_q) begin
            acc_pop_d = (first_q ? '0 : acc_pop_q) + ACCW'(s2_pop_q);
            acc_n_d   = (first_q ? '0 : acc_n_q) + ACCW'(s2_cnt_q);
            if (first_q)
                beat_cnt_d = BCW'(1);
            else if (beat_cnt_q != BCW'(MAXBEAT + 1))
                beat_cnt_d = beat_cnt_q + BCW'(1);
            ovf_d     = (first_q ? 1'b0 : ovf_q) | (beat_cnt_d > BCW'(MAXBEAT));
            first_d   = s2_last_q;
            s3_mode_d = s2_mode_q;
        end
    end

    // Output stage: final result on a completed vector, otherwise hold
    always_comb begin
        ovalid_d = s3_res_q;
        osum_d   = osum_q;
        obit_d   = obit_q;
        oovf_d   = oovf_q;
        if (s3_res_q) begin
            osum_d = s3_mode_q ? ({acc_pop_q[ACCW-2:0], 1'b0} - acc_n_q) : acc_pop_q;
            obit_d = $signed(osum_d) >= $signed(ithresh);
            oovf_d = ovf_q;
        end
    end

    // All state registers; iEN=0 freezes the whole pipeline
    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_mode_q  <= 1'b0;
            s1_x_q     <= '0;
            s1_mask_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_last_q  <= 1'b0;
            s2_mode_q  <= 1'b0;
            s2_pop_q   <= '0;
            s2_cnt_q   <= '0;
            s3_res_q   <= 1'b0;
            s3_mode_q  <= 1'b0;
            first_q    <= 1'b1;
            acc_pop_q  <= '0;
            acc_n_q    <= '0;
            beat_cnt_q <= '0;
            ovf_q      <= 1'b0;
            ovalid_q   <= 1'b0;
            osum_q     <= '0;
            obit_q     <= 1'b0;
            oovf_q     <= 1'b0;
        end else if (iEN) begin
            s1_valid_q <= s1_valid_d;
            s1_last_q  <= s1_last_d;
            s1_mode_q  <= s1_mode_d;
            s1_x_q     <= s1_x_d;
            s1_mask_q  <= s1_mask_d;
            s2_valid_q <= s2_valid_d;
            s2_last_q  <= s2_last_d;
            s2_mode_q  <= s2_mode_d;
            s2_pop_q   <= s2_pop_d;
            s2_cnt_q   <= s2_cnt_d;
            s3_res_q   <= s3_res_d;
            s3_mode_q  <= s3_mode_d;
            first_q    <= first_d;
            acc_pop_q  <= acc_pop_d;
            acc_n_q    <= acc_n_d;
            beat_cnt_q <= beat_cnt_d;
            ovf_q      <= ovf_d;
            ovalid_q   <= ovalid_d;
            osum_q     <= osum_d;
            obit_q     <= obit_d;
            oovf_q     <= oovf_d;
        end
    end

    assign oVALID = ovalid_q;
    assign osum   = osum_q;
    assign obit   = obit_q;
    assign oOVF   = oovf_q;

endmodule

// File: tb/tb_bnn_xnor_acc.sv
// Testbench for bnn_xnor_acc: directed test-plan vectors plus randomized
// traffic, checked every cycle against a vector-level reference model.
module tb_bnn_xnor_acc;

    localparam int unsigned WL      = 112;
    localparam int unsigned MAXBEAT = 4;
    localparam int unsigned ACCW    = $clog2(WL * MAXBEAT + 1) + 1;

    logic            iCLK, iRSTn, iEN, iVALID, iLAST, iMODE;
    logic [WL-1:0]   idata, iweight, imask;
    logic [ACCW-1:0] ithresh;
    logic            oVALID, obit, oOVF;
    logic [ACCW-1:0] osum;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    bnn_xnor_acc #(.WL(WL), .MAXBEAT(MAXBEAT)) dut (
        .iCLK(iCLK), .iRSTn(iRSTn), .iEN(iEN), .iVALID(iVALID), .iLAST(iLAST),
        .iMODE(iMODE), .idata(idata), .iweight(iweight), .imask(imask),
        .ithresh(ithresh), .oVALID(oVALID), .osum(osum), .obit(obit), .oOVF(oOVF)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    function automatic logic [WL-1:0] rnd();
        logic [WL-1:0] r;
        for (int i = 0; i < int'(WL); i++) r[i] = 1'($urandom_range(1, 0));
        return r;
    endfunction

    // ---------------- reference model / monitor ----------------
    typedef struct {
        logic [ACCW-1:0] sum;
        logic            ovf;
        int unsigned     due;
    } res_t;

    res_t            rq[$];
    int              cur_pop, cur_n, cur_beats;
    int unsigned     ecnt;
    logic            exp_valid, exp_bit, exp_ovf;
    logic [ACCW-1:0] exp_sum;

    initial begin
        logic            s_rst, s_en, s_v, s_l, s_m;
        logic [WL-1:0]   s_d, s_w, s_k;
        logic [ACCW-1:0] s_t;
        int              sv;
        res_t            r;
        cur_pop = 0; cur_n = 0; cur_beats = 0; ecnt = 0;
        exp_valid = 1'b0; exp_bit = 1'b0; exp_ovf = 1'b0; exp_sum = '0;
        forever begin
            @(posedge iCLK);
            s_rst = iRSTn; s_en = iEN; s_v = iVALID; s_l = iLAST; s_m = iMODE;
            s_d = idata; s_w = iweight; s_k = imask; s_t = ithresh;
            #1;
            if (!s_rst) begin
                rq.delete();
                cur_pop = 0; cur_n = 0; cur_beats = 0;
                exp_valid = 1'b0; exp_bit = 1'b0; exp_ovf = 1'b0; exp_sum = '0;
            end else if (s_en) begin
                ecnt++;
                if (s_v) begin
                    cur_pop   += $countones(~(s_d ^ s_w) & s_k);
                    cur_n     += $countones(s_k);
                    cur_beats += 1;
                    if (s_l) begin
                        sv    = s_m ? (2 * cur_pop - cur_n) : cur_pop;
                        r.sum = sv[ACCW-1:0];
                        r.ovf = (cur_beats > int'(MAXBEAT));
                        r.due = ecnt + 3;
                        rq.push_back(r);
                        cur_pop = 0; cur_n = 0; cur_beats = 0;
                    end
                end
                if (rq.size() != 0 && rq[0].due == ecnt) begin
                    exp_valid = 1'b1;
                    exp_sum   = rq[0].sum;
                    exp_ovf   = rq[0].ovf;
                    exp_bit   = ($signed(rq[0].sum) >= $signed(s_t));
                    void'(rq.pop_front());
                end else begin
                    exp_valid = 1'b0;
                end
            end
            chk("mon_valid", 32'(oVALID), 32'(exp_valid));
            chk("mon_sum",   32'(osum),   32'(exp_sum));
            chk("mon_bit",   32'(obit),   32'(exp_bit));
            chk("mon_ovf",   32'(oOVF),   32'(exp_ovf));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic beat(input logic [WL-1:0] d, input logic [WL-1:0] w,
                        input logic [WL-1:0] m, input logic last, input logic mode);
        @(negedge iCLK);
        idata = d; iweight = w; imask = m;
        iVALID = 1'b1; iLAST = last; iMODE = mode;
    endtask

    task automatic gap();
        @(negedge iCLK);
        iVALID = 1'b0; iLAST = 1'b0;
    endtask

    task automatic wait_res(input string tag, input int maxc, input logic [31:0] esum,
                            input logic ebit, input logic eovf);
        logic found;
        found = 1'b0;
        for (int i = 0; i < maxc && !found; i++) begin
            @(posedge iCLK);
            #1;
            if (iEN && oVALID) found = 1'b1;
        end
        chk({tag, "_seen"}, 32'(found), 32'd1);
        if (found) begin
            chk({tag, "_sum"}, 32'(osum), esum);
            chk({tag, "_bit"}, 32'(obit), 32'(ebit));
            chk({tag, "_ovf"}, 32'(oOVF), 32'(eovf));
        end
    endtask

    // ---------------- directed and random stimulus ----------------
    initial begin
        logic [WL-1:0] ones, z, w, m8;
        logic [31:0]   tmp;
        ones = '1; z = '0; m8 = '0; m8[7:0] = 8'hFF;
        iRSTn = 1'b0; iEN = 1'b1; iVALID = 1'b0; iLAST = 1'b0; iMODE = 1'b0;
        idata = '0; iweight = '0; imask = '0; ithresh = '0;
        repeat (3) @(negedge iCLK);
        chk("reset_valid", 32'(oVALID), 32'd0);
        chk("reset_sum",   32'(osum),   32'd0);
        chk("reset_ovf",   32'(oOVF),   32'd0);
        iRSTn = 1'b1;

        // single full-match beat, unipolar
        w = rnd(); ithresh = '0;
        beat(w, w, ones, 1'b1, 1'b0); gap();
        wait_res("single", 3, 112, 1'b1, 1'b0);

        // four beats, half mismatched, bipolar -> 0, below threshold 1
        ithresh = 1;
        beat(~w, w, ones, 1'b0, 1'b1);
        beat(~w, w, ones, 1'b0, 1'b1);
        beat(w,  w, ones, 1'b0, 1'b1);
        beat(w,  w, ones, 1'b1, 1'b1); gap();
        wait_res("four", 3, 0, 1'b0, 1'b0);

        // 8-bit mask, bipolar then unipolar
        ithresh = '0;
        beat(w, w, m8, 1'b1, 1'b1); gap();
        wait_res("mask_bi", 3, 8, 1'b1, 1'b0);
        beat(w, w, m8, 1'b1, 1'b0); gap();
        wait_res("mask_uni", 3, 8, 1'b1, 1'b0);

        // back-to-back vectors: 50+60, then 7
        beat(ones >> 50, z, ones, 1'b0, 1'b0);
        beat(ones >> 60, z, ones, 1'b1, 1'b0);
        beat(ones >> 7,  z, ones, 1'b1, 1'b0); gap();
        wait_res("b2b_a", 3, 110, 1'b1, 1'b0);
        wait_res("b2b_b", 1, 7,   1'b1, 1'b0);

        // gaps and pipeline stalls: 10+20+30
        beat(ones >> 10, z, ones, 1'b0, 1'b0); gap();
        beat(ones >> 20, z, ones, 1'b0, 1'b0);
        @(negedge iCLK); iEN = 1'b0; iVALID = 1'b0;
        @(negedge iCLK);
        @(negedge iCLK); iEN = 1'b1;
        beat(ones >> 30, z, ones, 1'b1, 1'b0); gap();
        @(negedge iCLK); iEN = 1'b0;
        @(negedge iCLK);
        @(negedge iCLK); iEN = 1'b1;
        wait_res("stall", 8, 60, 1'b1, 1'b0);
        @(negedge iCLK); iEN = 1'b0;
        @(posedge iCLK); #1;
        chk("hold_valid", 32'(oVALID), 32'd1);
        chk("hold_sum",   32'(osum),   32'd60);
        @(negedge iCLK); iEN = 1'b1;

        // five beats: overflow, 560 wraps to a negative 10-bit value
        for (int i = 0; i < 5; i++) beat(w, w, ones, (i == 4), 1'b0);
        gap();
        wait_res("ovf", 3, 560, 1'b0, 1'b1);

        // reset mid-vector discards in-flight beats
        beat(w, w, ones, 1'b0, 1'b0);
        beat(w, w, ones, 1'b0, 1'b0);
        @(negedge iCLK); iVALID = 1'b0; iRSTn = 1'b0;
        #1;
        chk("mrst_valid", 32'(oVALID), 32'd0);
        chk("mrst_sum",   32'(osum),   32'd0);
        chk("mrst_bit",   32'(obit),   32'd0);
        chk("mrst_ovf",   32'(oOVF),   32'd0);
        repeat (2) @(negedge iCLK);
        iRSTn = 1'b1;
        repeat (5) @(negedge iCLK);
        ithresh = 200;
        beat(w, w, ones, 1'b1, 1'b1); gap();
        wait_res("post_rst", 3, 112, 1'b0, 1'b0);

        // randomized traffic, checked by the monitor
        repeat (600) begin
            @(negedge iCLK);
            iEN    = ($urandom_range(9, 0) != 0);
            iVALID = ($urandom_range(9, 0) < 7);
            iLAST  = ($urandom_range(9, 0) < 3);
            iMODE  = 1'($urandom_range(1, 0));
            idata  = rnd();
            iweight = ($urandom_range(1, 0) != 0) ? rnd() : (idata ^ (rnd() & rnd() & rnd()));
            imask  = ($urandom_range(3, 0) == 0) ? ones : rnd();
            tmp    = $urandom;
            ithresh = tmp[ACCW-1:0];
        end
        @(negedge iCLK);
        iEN = 1'b1; iVALID = 1'b1; iLAST = 1'b1;
        @(negedge iCLK);
        iVALID = 1'b0; iLAST = 1'b0;
        repeat (8) @(negedge iCLK);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/bnn_xnor_acc.md
# bnn_xnor_acc

Parametrised, pipelined XNOR-popcount neuron accumulator for the binarised CNN datapath. It extends the fixed 112-bit single-shot XNOR/popcount to fan-ins wider than one word: a neuron's input vector arrives as 1..MAXBEAT beats of WL bits each. The block applies per-bit masking, accumulates across beats and produces either a unipolar popcount or a bipolar dot product. It also emits a thresholded sign-activation bit for the next binarised layer.

## Interface
- WL, 112, bits per beat (≥2)
- MAXBEAT, 4, maximum beats per vector (≥1)
- PW, $clog2(WL+1), per-beat popcount width (derived, 7 at defaults)
- ACCW, $clog2(WL*MAXBEAT+1)+1, signed result width (derived, 10 at defaults)

Ports:
- iCLK  in  1  clock; all state on rising edge
- iRSTn  in  1  asynchronous, active-low reset
- iEN  in  1  global pipeline enable; 0 freezes every register
- iVALID  in  1  beat valid
- iLAST  in  1  final beat of the current vector (qualified by iVALID)
- iMODE  in  1  0 = unipolar popcount, 1 = bipolar (2·pop − n)
- idata  in  WL  binarised activations
- iweight  in  WL  binarised weights
- imask  in  WL  1 = bit participates; 0 = ignored (not counted in pop or n)
- ithresh  in  ACCW  signed activation threshold
- oVALID  out  1  result valid
- osum  out  ACCW  signed result
- obit  out  1  sign activation: osum ≥ ithresh (signed)
- oOVF  out  1  vector exceeded MAXBEAT beats

## Operation
- A beat is accepted when iEN=1 and iVALID=1. With iEN=0, nothing is accepted or advanced.
- S1 (register): x = ~(idata ^ iweight) & imask, along with the mask, valid, last and mode flags.
- S2 (register): pop = popcount(x) and cnt = popcount(mask), each PW bits, via a balanced adder tree.
- S3 (accumulate): an internal first flag is 1 after reset and after every accepted last beat.
  - acc_pop = (first ? 0 : acc_pop) + pop, and likewise acc_n.
  - A beat counter counts beats in the current vector. The beat that makes it exceed MAXBEAT sets a sticky ovf for that vector.
  - The counter and ovf clear on the first beat of the next vector.
- On an S3 beat carrying last:
  - osum = iMODE_s3 ? 2·acc_pop − acc_n : acc_pop, computed in ACCW-bit signed arithmetic; wraps if ovf.
  - obit = ($signed(osum_next) ≥ $signed(ithresh)). ithresh is sampled in that same cycle.
  - oOVF = ovf including the current beat.
  - oVALID = 1.
- A single-beat vector (iVALID & iLAST together) is legal.
- Mode is sampled per beat. The mode on the last beat governs the result.
- Non-last beats produce no output. osum, obit and oOVF hold their last values until the next result.

## Timing
- Reset (async assert, sync release at iCLK edge): all pipeline valid flags 0, first=1, accumulators 0, beat counter 0, oVALID=0, osum=0, obit=0, oOVF=0.
- Latency: a last beat accepted at edge k produces its result at edge k+3, counting only iEN=1 edges.
- Throughput: one beat per cycle. The first beat of a new vector may directly follow the previous last beat with no bubble.
- oVALID is high for exactly one enabled cycle per vector. If iEN drops while oVALID=1, oVALID, osum, obit and oOVF hold. Consumers qualify with iEN & oVALID.
- iVALID=0 gaps inside a vector are allowed; the accumulator holds.
- Reset mid-vector discards the partial accumulation and all in-flight beats. No oVALID is produced for them.

## Test plan
- Single beat, WL=112, idata=iweight, imask all 1, iMODE=0 -> 3 cycles later oVALID=1, osum=112, obit=1 with ithresh=0.
- Four beats, idata=~iweight on beats 0–1, equal on beats 2–3, full mask, iMODE=1 -> acc_pop=224, acc_n=448, osum=0; ithresh=1 -> obit=0.
- Mask test: one beat, imask=0x0…FF (8 bits), all bits match, iMODE=1 -> osum=8. The same vector with iMODE=0 also gives osum=8.
- Back-to-back: vector A (2 beats, pop 50+60) immediately followed by vector B (1 beat, pop 7), iMODE=0 -> osum=110 then osum=7 on consecutive cycles; B is not contaminated by A.
- Stall/gap: a 3-beat vector with iVALID=0 gaps and iEN=0 for 2 cycles mid-pipeline -> same osum as the unstalled run, latency +2 cycles, a single oVALID pulse.
- Overflow/reset: 5 beats with MAXBEAT=4 -> oOVF=1 on that result. Asserting iRSTn=0 after beat 2 of a new vector -> all outputs 0, no oVALID; the next clean vector gives the correct sum.
